// File: rtl/axi_pkg.sv
// axi_pkg: AXI widths, fixed encodings and master-read FSM state type. Rev 1.0
`default_nettype none

package axi_pkg;

  localparam int AXI_ID_BITS   = 4;
  localparam int AXI_ADDR_BITS = 32;
  localparam int AXI_LEN_BITS  = 4;
  localparam int AXI_SIZE_BITS = 3;
  localparam int AXI_DATA_BITS = 32;

  localparam logic [AXI_SIZE_BITS-1:0] SIZE_WORD   = 3'b010;
  localparam logic [1:0]               BURST_INCR  = 2'b01;
  localparam logic [1:0]               RESP_OKAY   = 2'b00;
  localparam logic [1:0]               RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } mr_state_t;

  function automatic logic [AXI_LEN_BITS-1:0] clamp_len(
    input logic [AXI_LEN_BITS-1:0] len,
    input logic [AXI_LEN_BITS-1:0] max_len
  );
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

`default_nettype wire

// File: rtl/master_read_if.sv
// master_read_if: AXI AR + R channel bundle with master/slave views. Rev 1.0
`default_nettype none

interface master_read_if;
  import axi_pkg::*;

  logic [AXI_ID_BITS-1:0]   ARID;
  logic [AXI_ADDR_BITS-1:0] ARADDR;
  logic [AXI_LEN_BITS-1:0]  ARLEN;
  logic [AXI_SIZE_BITS-1:0] ARSIZE;
  logic [1:0]               ARBURST;
  logic                     ARVALID;
  logic                     ARREADY;
  logic [AXI_ID_BITS-1:0]   RID;
  logic [AXI_DATA_BITS-1:0] RDATA;
  logic [1:0]               RRESP;
  logic                     RLAST;
  logic                     RVALID;
  logic                     RREADY;

  modport master (
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
    input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );

  modport slave (
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
    output ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );

endinterface

`default_nettype wire

// File: rtl/master_read.sv
// master_read: CPU-side AXI read master, one AR handshake plus R burst per core request. Rev 1.0
`default_nettype none

module master_read
  import axi_pkg::*;
#(
  parameter logic [AXI_ID_BITS-1:0]  MASTER_ID = 4'd0,
  parameter logic [AXI_LEN_BITS-1:0] MAX_LEN   = 4'd3
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  input  wire logic                     req_valid,
  input  wire logic [AXI_ADDR_BITS-1:0] req_addr,
  input  wire logic [AXI_LEN_BITS-1:0]  req_len,
  output logic                          req_ready,
  output logic                          rsp_valid,
  output logic [AXI_DATA_BITS-1:0]      rsp_data,
  output logic                          rsp_last,
  output logic                          rsp_err,
  output logic                          stall,
  master_read_if.master                 axi
);

  mr_state_t                r_state;
  mr_state_t                w_state_nxt;
  logic [AXI_ADDR_BITS-1:0] r_addr;
  logic [AXI_LEN_BITS-1:0]  r_len;
  logic [AXI_LEN_BITS-1:0]  r_cnt;
  logic                     r_rsp_valid;
  logic [AXI_DATA_BITS-1:0] r_rsp_data;
  logic                     r_rsp_last;
  logic                     r_rsp_err;

  logic w_req_ready;
  logic w_stall;
  logic w_arvalid;
  logic w_rready;
  logic w_beat;
  logic w_cnt_last;
  logic w_done;

  assign w_beat     = axi.RVALID && w_rready;
  assign w_cnt_last = (r_cnt == r_len);
  // An early RLAST still ends the burst; the beat is flagged as an error.
  assign w_done     = w_beat && (w_cnt_last || axi.RLAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (req_valid)    w_state_nxt = ST_ADDR;
      ST_ADDR: if (axi.ARREADY)  w_state_nxt = ST_DATA;
      ST_DATA: if (w_done)       w_state_nxt = ST_IDLE;
      default:                   w_state_nxt = ST_IDLE;
    endcase
  end

  // Gated by rst so every handshake/stall output reads 0 while reset is held.
  always_comb begin
    w_req_ready = 1'b0;
    w_stall     = 1'b0;
    w_arvalid   = 1'b0;
    w_rready    = 1'b0;
    if (rst) begin
      case (r_state)
        ST_IDLE: begin
          w_req_ready = 1'b1;
          w_stall     = req_valid || (r_rsp_valid && r_rsp_last);
        end
        ST_ADDR: begin
          w_arvalid = 1'b1;
          w_stall   = 1'b1;
        end
        ST_DATA: begin
          w_rready = 1'b1;
          w_stall  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr <= '0;
      r_len  <= '0;
      r_cnt  <= '0;
    end else begin
      if (r_state == ST_IDLE && req_valid) begin
        r_addr <= req_addr;
        r_len  <= clamp_len(req_len, MAX_LEN);
      end
      if (r_state == ST_ADDR && axi.ARREADY) begin
        r_cnt <= '0;
      end else if (w_beat) begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_last  <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= w_beat;
      r_rsp_last  <= w_beat && (w_cnt_last || axi.RLAST);
      r_rsp_err   <= w_beat && ((axi.RRESP != RESP_OKAY) ||
                                (axi.RID != MASTER_ID)   ||
                                (axi.RLAST != w_cnt_last));
      if (w_beat) begin
        r_rsp_data <= axi.RDATA;
      end
    end
  end

  assign req_ready   = w_req_ready;
  assign stall       = w_stall;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_data    = r_rsp_data;
  assign rsp_last    = r_rsp_last;
  assign rsp_err     = r_rsp_err;

  assign axi.ARID    = MASTER_ID;
  assign axi.ARADDR  = r_addr;
  assign axi.ARLEN   = r_len;
  assign axi.ARSIZE  = SIZE_WORD;
  assign axi.ARBURST = BURST_INCR;
  assign axi.ARVALID = w_arvalid;
  assign axi.RREADY  = w_rready;

endmodule

`default_nettype wire
